adc_scan_ctrl: RTL and testbench

//  Autonomous sequencer for the board serial ADC (12-bit, 4-bit address, pipelined result, EOC).

---
 rtl/adc_scan_ctrl_if.sv | 10 +
 rtl/adc_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: serial ADC pin bundle (sck/sdi/ncs driven by the controller, sdo/eoc returned by the ADC)
interface adc_scan_ctrl_if;
  logic sck;
  logic sdi;
  logic ncs;
  logic sdo;
  logic eoc;
  modport master(output sck, sdi, ncs, input sdo, eoc);
  modport slave(input sck, sdi, ncs, output sdo, eoc);
endinterface

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: autonomous serial-ADC channel scanner with per-channel result file and JTAG pin arbitration
// Ports: clk; hard_rst async active low; scan_en enables scanning; jtag_req/jtag_sck/jtag_sdi/jtag_ncs
// bit-bang path granted by jtag_gnt; adc (master) drives sck/sdi/ncs and receives sdo/eoc;
// rd_ch selects rd_data/rd_valid; scan_done pulses once per scan; eoc_err flags an EOC timeout.
module adc_scan_ctrl #(
  parameter int NCH = 11,
  parameter int SCK_DIV = 4,
  parameter int GAP = 1000,
  parameter int EOC_TMO = 255
) (
  input  logic                   clk,
  input  logic                   hard_rst,
  input  logic                   scan_en,
  input  logic                   jtag_req,
  input  logic                   jtag_sck,
  input  logic                   jtag_sdi,
  input  logic                   jtag_ncs,
  output logic                   jtag_gnt,
  adc_scan_ctrl_if.master        adc,
  input  logic [3:0]             rd_ch,
  output logic [11:0]            rd_data,
  output logic                   rd_valid,
  output logic                   scan_done,
  output logic                   eoc_err
);
  localparam int MX = GAP > EOC_TMO ? GAP : EOC_TMO;
  localparam int CW = $clog2(MX + SCK_DIV + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_CSHI, S_WAITEOC, S_GAP, S_JTAG} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bidx, bidx_n, frame, frame_n;
  logic hi, hi_n, sck, sck_n, sdi, sdi_n, ncs, ncs_n, gnt_n, done_n, err_n, sample, store;
  logic half_end, eoc_ok, tmo;
  logic [11:0] shreg, word;
  // entries at or above NCH are never written, so out-of-range reads return 0 and invalid
  logic [15:0][11:0] res;
  logic [15:0] valid;
  // the frame after the last channel sends a dummy address only to clock out the final result
  assign word = {frame < 4'(NCH) ? frame : 4'hB, 8'h00};
  assign half_end = cnt == CW'(SCK_DIV - 1);
  assign eoc_ok = cnt >= CW'(2) && adc.eoc;
  assign tmo = cnt == CW'(EOC_TMO);
  assign adc.sck = sck;
  assign adc.sdi = sdi;
  assign adc.ncs = ncs;
  assign rd_data = res[rd_ch];
  assign rd_valid = valid[rd_ch];
  always_comb begin
    state_n = state;
    cnt_n = &cnt ? cnt : cnt + CW'(1);
    bidx_n = bidx;
    hi_n = hi;
    frame_n = frame;
    sck_n = sck;
    sdi_n = sdi;
    ncs_n = ncs;
    gnt_n = jtag_gnt;
    done_n = 1'b0;
    err_n = eoc_err;
    sample = 1'b0;
    store = 1'b0;
    case (state)
      S_IDLE: begin
        sck_n = 1'b0;
        sdi_n = 1'b0;
        ncs_n = 1'b1;
        cnt_n = '0;
        if (jtag_req) begin
          state_n = S_JTAG;
          gnt_n = 1'b1;
          sck_n = jtag_sck;
          sdi_n = jtag_sdi;
          ncs_n = jtag_ncs;
        end else if (scan_en) begin
          state_n = S_SETUP;
          frame_n = '0;
          err_n = 1'b0;
          ncs_n = 1'b0;
        end
      end
      S_SETUP: if (half_end) begin
        state_n = S_SHIFT;
        cnt_n = '0;
        bidx_n = '0;
        hi_n = 1'b0;
        sdi_n = word[11];
      end
      S_SHIFT: if (half_end) begin
        cnt_n = '0;
        hi_n = ~hi;
        sck_n = ~hi;
        sample = ~hi;
        if (hi && bidx == 4'd11) state_n = S_CSHI;
        else if (hi) begin
          bidx_n = bidx + 4'd1;
          sdi_n = word[4'd10 - bidx];
        end
      end
      S_CSHI: if (half_end) begin
        state_n = S_WAITEOC;
        cnt_n = '0;
        ncs_n = 1'b1;
        sdi_n = 1'b0;
        store = frame != 4'd0;
      end
      S_WAITEOC: if (eoc_ok || tmo) begin
        cnt_n = '0;
        err_n = eoc_err | ~eoc_ok;
        if (frame == 4'(NCH)) begin
          state_n = S_GAP;
          done_n = 1'b1;
        end else if (scan_en) begin
          state_n = S_SETUP;
          frame_n = frame + 4'd1;
          ncs_n = 1'b0;
        end else state_n = S_IDLE;
      end
      S_GAP: begin
        if (jtag_req) begin
          state_n = S_JTAG;
          gnt_n = 1'b1;
          sck_n = jtag_sck;
          sdi_n = jtag_sdi;
          ncs_n = jtag_ncs;
        end else if (!scan_en) state_n = S_IDLE;
        else if (cnt == CW'(GAP - 1)) begin
          state_n = S_SETUP;
          cnt_n = '0;
          frame_n = '0;
          err_n = 1'b0;
          ncs_n = 1'b0;
        end
      end
      S_JTAG: begin
        sck_n = jtag_req & jtag_sck;
        sdi_n = jtag_req & jtag_sdi;
        ncs_n = ~jtag_req | jtag_ncs;
        if (!jtag_req) begin
          state_n = S_GAP;
          gnt_n = 1'b0;
          cnt_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge hard_rst)
    if (!hard_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      bidx <= '0;
      hi <= 1'b0;
      frame <= '0;
      sck <= 1'b0;
      sdi <= 1'b0;
      ncs <= 1'b1;
      jtag_gnt <= 1'b0;
      scan_done <= 1'b0;
      eoc_err <= 1'b0;
      shreg <= '0;
      res <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bidx <= bidx_n;
      hi <= hi_n;
      frame <= frame_n;
      sck <= sck_n;
      sdi <= sdi_n;
      ncs <= ncs_n;
      jtag_gnt <= gnt_n;
      scan_done <= done_n;
      eoc_err <= err_n;
      if (sample) shreg <= {shreg[10:0], adc.sdo};
      if (store) begin
        res[frame - 4'd1] <= shreg;
        valid[frame - 4'd1] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with a pipelined ADC model returning 0xA00+address
module tb_adc_scan_ctrl;
  logic clk = 1'b0;
  logic hard_rst, scan_en, jtag_req, jtag_sck, jtag_sdi, jtag_ncs, jtag_gnt;
  logic [3:0] rd_ch;
  logic [11:0] rd_data;
  logic rd_valid, scan_done, eoc_err, eoc_stuck;
  int errors = 0, checks = 0;
  int cyc = 0, run = 0, nrise = 0, ncs_run = 0, frames = 0, done_cnt = 0;
  int last_len = 0, last_nrise = 0, t_done = 0, gap_len = 0, n;
  int hi_min = 99, hi_max = 0, lo_min = 99, lo_max = 0;
  bit gap_pend = 0;
  logic sck_p = 1'b0, ncs_p = 1'b1;
  logic [11:0] sdi_sr = '0, last_sdi = '0, m_out = '0;
  logic [3:0] m_prev = 4'hF;
  adc_scan_ctrl_if adc_bus();
  adc_scan_ctrl #(.NCH(3), .SCK_DIV(2), .GAP(20), .EOC_TMO(15)) dut (
    .clk(clk), .hard_rst(hard_rst), .scan_en(scan_en),
    .jtag_req(jtag_req), .jtag_sck(jtag_sck), .jtag_sdi(jtag_sdi), .jtag_ncs(jtag_ncs),
    .jtag_gnt(jtag_gnt), .adc(adc_bus), .rd_ch(rd_ch), .rd_data(rd_data),
    .rd_valid(rd_valid), .scan_done(scan_done), .eoc_err(eoc_err)
  );
  always #5 clk = ~clk;
  assign adc_bus.eoc = ~eoc_stuck;
  always @(negedge clk) begin
    cyc++;
    if (!adc_bus.ncs && ncs_p) begin
      ncs_run = 0;
      nrise = 0;
      m_out = {8'hA0, m_prev};
      if (gap_pend && !jtag_gnt) begin
        gap_len = cyc - t_done;
        gap_pend = 0;
      end
    end
    if (adc_bus.sck != sck_p) begin
      if (sck_p) begin
        hi_min = run < hi_min ? run : hi_min;
        hi_max = run > hi_max ? run : hi_max;
      end else if (nrise > 0 && !adc_bus.ncs) begin
        lo_min = run < lo_min ? run : lo_min;
        lo_max = run > lo_max ? run : lo_max;
      end
      run = 1;
    end else run++;
    if (adc_bus.sck && !sck_p && !adc_bus.ncs) begin
      nrise++;
      sdi_sr = {sdi_sr[10:0], adc_bus.sdi};
      m_out = m_out << 1;
    end
    if (!adc_bus.ncs) ncs_run++;
    if (adc_bus.ncs && !ncs_p) begin
      m_prev = sdi_sr[11:8];
      if (!jtag_gnt) begin
        frames++;
        last_len = ncs_run;
        last_sdi = sdi_sr;
        last_nrise = nrise;
      end
    end
    if (scan_done) begin
      done_cnt++;
      t_done = cyc;
      gap_pend = 1;
    end
    adc_bus.sdo = m_out[11];
    sck_p = adc_bus.sck;
    ncs_p = adc_bus.ncs;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] ch, input logic [11:0] d, input logic v);
    rd_ch = ch;
    #1;
    chk({tag, "_data"}, rd_data, d);
    chk({tag, "_valid"}, rd_valid, v);
    step();
  endtask
  function automatic bit cond(input int what, input int k);
    return what == 0 ? frames >= k : what == 1 ? done_cnt >= k : what == 2 ? !adc_bus.ncs : jtag_gnt;
  endfunction
  task automatic wait_for(input string tag, input int what, input int k);
    int t = 0;
    while (!cond(what, k) && t < 1000) begin
      step();
      t++;
    end
    chk(tag, cond(what, k), 1);
  endtask
  initial begin
    hard_rst = 1'b0;
    scan_en = 1'b0;
    jtag_req = 1'b0;
    jtag_sck = 1'b0;
    jtag_sdi = 1'b0;
    jtag_ncs = 1'b1;
    rd_ch = 4'd1;
    eoc_stuck = 1'b0;
    step();
    step();
    chk("rst_sck", adc_bus.sck, 0);
    chk("rst_sdi", adc_bus.sdi, 0);
    chk("rst_ncs", adc_bus.ncs, 1);
    chk("rst_gnt", jtag_gnt, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_err", eoc_err, 0);
    rd_chk("rst_rd1", 4'd1, 12'h000, 1'b0);
    hard_rst = 1'b1;
    step();
    chk("idle_ncs", adc_bus.ncs, 1);
    scan_en = 1'b1;
    wait_for("wait_frame0", 0, 1);
    chk("ncs_low_len", last_len, 52);
    chk("sck_rises", last_nrise, 12);
    chk("sdi_frame0", last_sdi, 12'h000);
    chk("sck_hi_min", hi_min, 2);
    chk("sck_hi_max", hi_max, 2);
    chk("sck_lo_min", lo_min, 2);
    chk("sck_lo_max", lo_max, 2);
    wait_for("wait_frame2", 0, 3);
    chk("sdi_frame2", last_sdi, 12'h200);
    wait_for("wait_frame3", 0, 4);
    chk("sdi_frame3", last_sdi, 12'hB00);
    wait_for("wait_scan1", 1, 1);
    chk("done_high", scan_done, 1);
    chk("frames_scan1", frames, 4);
    chk("err_scan1", eoc_err, 0);
    rd_chk("rd_ch0", 4'd0, 12'hA00, 1'b1);
    rd_chk("rd_ch1", 4'd1, 12'hA01, 1'b1);
    rd_chk("rd_ch2", 4'd2, 12'hA02, 1'b1);
    rd_chk("rd_ch3", 4'd3, 12'h000, 1'b0);
    rd_chk("rd_ch15", 4'd15, 12'h000, 1'b0);
    chk("done_once", done_cnt, 1);
    wait_for("wait_scan2", 1, 2);
    chk("frames_scan2", frames, 8);
    chk("gap_len", gap_len, 20);
    rd_chk("rd2_ch1", 4'd1, 12'hA01, 1'b1);
    eoc_stuck = 1'b1;
    wait_for("wait_frame9", 0, 9);
    repeat (15) step();
    chk("err_before_tmo", eoc_err, 0);
    step();
    chk("err_at_tmo", eoc_err, 1);
    wait_for("wait_scan3", 1, 3);
    chk("frames_scan3", frames, 12);
    chk("err_scan3", eoc_err, 1);
    eoc_stuck = 1'b0;
    wait_for("wait_scan4_start", 2, 0);
    chk("err_cleared", eoc_err, 0);
    repeat (10) step();
    jtag_req = 1'b1;
    step();
    chk("gnt_held_off", jtag_gnt, 0);
    wait_for("wait_gnt", 3, 0);
    chk("gnt_done_cnt", done_cnt, 4);
    chk("gnt_frames", frames, 16);
    chk("gnt_last_len", last_len, 52);
    chk("err_scan4", eoc_err, 0);
    rd_chk("rd4_ch2", 4'd2, 12'hA02, 1'b1);
    jtag_ncs = 1'b0;
    chk("jtag_ncs_lag", adc_bus.ncs, 1);
    step();
    chk("jtag_ncs_follow", adc_bus.ncs, 0);
    jtag_sck = 1'b1;
    jtag_sdi = 1'b1;
    step();
    chk("jtag_sck", adc_bus.sck, 1);
    chk("jtag_sdi", adc_bus.sdi, 1);
    jtag_sck = 1'b0;
    jtag_sdi = 1'b0;
    jtag_ncs = 1'b1;
    step();
    chk("jtag_ncs_high", adc_bus.ncs, 1);
    jtag_req = 1'b0;
    step();
    chk("rel_gnt", jtag_gnt, 0);
    chk("rel_sck", adc_bus.sck, 0);
    n = 1;
    while (adc_bus.ncs && n < 100) begin
      step();
      n++;
    end
    chk("rel_gap", n, 21);
    wait_for("wait_frame17", 0, 17);
    wait_for("wait_frame1_start", 2, 0);
    scan_en = 1'b0;
    wait_for("wait_frame18", 0, 18);
    repeat (10) step();
    chk("stop_ncs", adc_bus.ncs, 1);
    chk("stop_frames", frames, 18);
    chk("stop_done", done_cnt, 4);
    jtag_req = 1'b1;
    step();
    chk("idle_gnt", jtag_gnt, 1);
    jtag_req = 1'b0;
    step();
    chk("idle_rel", jtag_gnt, 0);
    rd_ch = 4'd1;
    scan_en = 1'b1;
    wait_for("wait_rst_frame", 2, 0);
    repeat (10) step();
    #2 hard_rst = 1'b0;
    #1;
    chk("arst_ncs", adc_bus.ncs, 1);
    chk("arst_sck", adc_bus.sck, 0);
    chk("arst_sdi", adc_bus.sdi, 0);
    chk("arst_gnt", jtag_gnt, 0);
    chk("arst_err", eoc_err, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_data", rd_data, 12'h000);
    scan_en = 1'b0;
    step();
    hard_rst = 1'b1;
    step();
    chk("post_rst_ncs", adc_bus.ncs, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
